// File: rtl/adc_spi_rx.sv
// SPI master front end for an 8-bit serial ADC: frames conversions with cs_n/sclk,
// captures the data bits from sdata and presents each sample with a one-cycle valid strobe.
module adc_spi_rx #(
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned N_SCLK   = 16,
  parameter int unsigned DATA_POS = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CS_QUIET = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              stop,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_valid,
  output logic              busy
);

  localparam int unsigned CNT_MAX = (SCLK_DIV > CS_QUIET) ? SCLK_DIV : CS_QUIET;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam int unsigned BW      = (N_SCLK > 1) ? $clog2(N_SCLK) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              hi_q, hi_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              run_q, run_d;
  logic              in_data;

  // stop has priority over start when both are low in the same cycle
  always_comb begin
    run_d = run_q;
    if (!stop) begin
      run_d = 1'b0;
    end else if (!start) begin
      run_d = 1'b1;
    end
  end

  assign in_data = (int'(bit_q) >= int'(DATA_POS)) &&
                   (int'(bit_q) <  int'(DATA_POS + DATA_W));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    hi_d    = hi_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (run_q) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SCLK_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
          sclk_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(SCLK_DIV - 1)) begin
          cnt_d = '0;
          if (!hi_q) begin
            // sample on the same edge that raises sclk: data has settled for the whole low phase
            hi_d   = 1'b1;
            sclk_d = 1'b1;
            if (in_data) begin
              sh_d = {sh_q[DATA_W-2:0], sdata};
            end
          end else if (bit_q == BW'(N_SCLK - 1)) begin
            state_d = QUIET;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
            data_d  = sh_q;
            valid_d = 1'b1;
          end else begin
            bit_d  = bit_q + 1'b1;
            hi_d   = 1'b0;
            sclk_d = 1'b0;
          end
        end
      end
      QUIET: begin
        if (cnt_q == CW'(CS_QUIET - 1)) begin
          cnt_d = '0;
          if (run_q) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      run_q   <= run_d;
    end
  end

  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign adc_data  = data_q;
  assign adc_valid = valid_q;
  assign busy      = busy_q;

endmodule
